// File: rtl/iterative_compare_pkg.sv
// ----------------------------------------------------------------------------
// iterative_compare_pkg
// Shared definitions for the iterative comparator:
//   - state_t   : FSM state encoding (IDLE = 0, BUSY = 1, DONE = 2)
//   - nslice    : number of CHUNK-bit slices in a WIDTH-bit operand
//   - idx_width : width of the slice index counter ($clog2, minimum 1 bit)
// ----------------------------------------------------------------------------
package iterative_compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nslice(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slice_compare.sv
// ----------------------------------------------------------------------------
// slice_compare
// Combinational compare of one CHUNK-bit slice of the two operands.
// Ports:
//   a, b        : slice of operand A and operand B
//   msb_signed  : slice holds the operand sign bit and the compare is signed
//   eq          : a == b
//   lt          : a < b (signed-aware when msb_signed is set)
//   a_nz        : slice of A is non-zero
// ----------------------------------------------------------------------------
module slice_compare #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             msb_signed,
    output logic             eq,
    output logic             lt,
    output logic             a_nz
);

    logic [CHUNK-1:0] flip;

    // Inverting the sign bit of both slices turns a two's-complement
    // ordering into an unsigned one, so a single unsigned comparator serves
    // both signed and unsigned modes. Equality is unaffected by the flip.
    always_comb begin
        flip            = '0;
        flip[CHUNK-1]   = msb_signed;
    end

    assign eq   = (a == b);
    assign lt   = ((a ^ flip) < (b ^ flip));
    assign a_nz = (a != '0);

endmodule

// File: rtl/iterative_compare.sv
// ----------------------------------------------------------------------------
// iterative_compare
// Multi-cycle comparator: walks two WIDTH-bit operands one CHUNK-bit slice
// per cycle, most significant slice first, and reports equality, less-than
// (signed or unsigned) and zero/sign flags of A.
//
// Ports:
//   clock, reset         : rising-edge clock, async active-high reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE)
//   A, B, Signed         : operands and signed-compare select
//   out_valid / out_ready: result handshake (out_valid only in DONE)
//   EQ, LT, GZ, LZ, GEZ, LEZ : result flags, held while out_valid is high
//   busy                 : an operation is in progress (state != IDLE)
//
// Optional feature (macro ITERATIVE_COMPARE_EARLY_TERM_EN):
//   When defined, BUSY ends as soon as both the LT decision and the
//   non-zero status of A are known, giving data-dependent latency.
//   When undefined, latency is always exactly WIDTH/CHUNK cycles.
// ----------------------------------------------------------------------------
module iterative_compare
    import iterative_compare_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             EQ,
    output logic             LT,
    output logic             GZ,
    output logic             LZ,
    output logic             GEZ,
    output logic             LEZ,
    output logic             busy
);

    localparam int              N    = nslice(WIDTH, CHUNK);
    localparam int              IDXW = idx_width(N);
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    state_t            state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              signed_reg;
    logic [IDXW-1:0]   idx;
    logic              eq_acc;
    logic              lt_dec;
    logic              lt_acc;
    logic              nz_acc;

    logic [CHUNK-1:0]  a_slices [N];
    logic [CHUNK-1:0]  b_slices [N];

    logic              msb_signed;
    logic              sl_eq;
    logic              sl_lt;
    logic              sl_nz;
    logic              decide_now;
    logic              eq_next;
    logic              lt_next;
    logic              dec_next;
    logic              nz_next;
    logic              finish;

    // Split the latched operands into an array of slices so the current
    // slice is a plain array lookup by the index counter.
    for (genvar g = 0; g < N; g++) begin : g_slice
        assign a_slices[g] = a_reg[g*CHUNK +: CHUNK];
        assign b_slices[g] = b_reg[g*CHUNK +: CHUNK];
    end

    // Only the top slice carries the sign bit.
    assign msb_signed = signed_reg & (idx == LAST);

    slice_compare #(
        .CHUNK      (CHUNK)
    ) u_slice_compare (
        .a          (a_slices[idx]),
        .b          (b_slices[idx]),
        .msb_signed (msb_signed),
        .eq         (sl_eq),
        .lt         (sl_lt),
        .a_nz       (sl_nz)
    );

    // The first differing slice (from the top) decides LT and clears EQ;
    // later slices cannot change a decision already made.
    assign decide_now = ~lt_dec & ~sl_eq;
    assign eq_next    = decide_now ? 1'b0  : eq_acc;
    assign lt_next    = decide_now ? sl_lt : lt_acc;
    assign dec_next   = lt_dec | decide_now;
    assign nz_next    = nz_acc | sl_nz;

`ifdef ITERATIVE_COMPARE_EARLY_TERM_EN
    // Once LT is decided and A is known non-zero, the remaining slices
    // cannot change any flag, so the walk may stop early.
    assign finish = (idx == '0) | (dec_next & nz_next);
`else
    assign finish = (idx == '0);
`endif

    // Single FSM block: latches operands in IDLE, accumulates one slice per
    // cycle in BUSY, registers the result flags on entry to DONE and holds
    // them until the consumer accepts. All handshake outputs are registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            signed_reg <= 1'b0;
            idx        <= '0;
            eq_acc     <= 1'b0;
            lt_dec     <= 1'b0;
            lt_acc     <= 1'b0;
            nz_acc     <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            EQ         <= 1'b0;
            LT         <= 1'b0;
            GZ         <= 1'b0;
            LZ         <= 1'b0;
            GEZ        <= 1'b0;
            LEZ        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= A;
                        b_reg      <= B;
                        signed_reg <= Signed;
                        idx        <= LAST;
                        eq_acc     <= 1'b1;
                        lt_dec     <= 1'b0;
                        lt_acc     <= 1'b0;
                        nz_acc     <= 1'b0;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    eq_acc <= eq_next;
                    lt_acc <= lt_next;
                    lt_dec <= dec_next;
                    nz_acc <= nz_next;
                    if (finish) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        EQ        <= eq_next;
                        LT        <= lt_next;
                        if (signed_reg) begin
                            LZ  <= a_reg[WIDTH-1];
                            GEZ <= ~a_reg[WIDTH-1];
                            GZ  <= ~a_reg[WIDTH-1] & nz_next;
                            LEZ <= a_reg[WIDTH-1] | ~nz_next;
                        end else begin
                            LZ  <= 1'b0;
                            GEZ <= 1'b1;
                            GZ  <= nz_next;
                            LEZ <= ~nz_next;
                        end
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        EQ        <= 1'b0;
                        LT        <= 1'b0;
                        GZ        <= 1'b0;
                        LZ        <= 1'b0;
                        GEZ       <= 1'b0;
                        LEZ       <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
